// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-cycle IF/ID register, relative redirect with flush.
// Optional FETCH_ABS_JMP_EN adds jmp_abs for absolute redirect targets.
module fetch_unit #(
  parameter int                   PC_W      = 8,
  parameter int                   INSTR_W   = 8,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
`ifdef FETCH_ABS_JMP_EN
  input  logic               jmp_abs,
`endif
  input  logic [PC_W-1:0]    jmp_offset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;

  assign imem_addr = pc;

  // Target is relative to the instruction being presented, not the in-flight fetch.
`ifdef FETCH_ABS_JMP_EN
  assign target = jmp_abs ? jmp_offset : PC_W'(if_pc + jmp_offset);
`else
  assign target = PC_W'(if_pc + jmp_offset);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
    end else if (redirect) begin
      // Flush the wrong-path fetch; if_pc is left as-is since it is don't-care here.
      pc       <= target;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= PC_W'(pc + 1'b1);
      if_instr <= imem_data;
      if_pc    <= pc;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected post-edge state, monitor pops and compares.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic       jmp_abs = 1'b0;
  logic [7:0] jmp_offset = '0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] if_instr;
  logic [7:0] if_pc;
  logic       if_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] instr;
    logic [7:0] pc;
    logic       valid;
    logic       ck_pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign imem_data = imem_addr + 8'h10;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
`ifdef FETCH_ABS_JMP_EN
    .jmp_abs(jmp_abs),
`endif
    .jmp_offset(jmp_offset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_valid(if_valid)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge: drive inputs, queue the state expected after the next rising edge.
  task automatic step(input string name, input logic st, input logic rd, input logic ab,
                      input logic [7:0] off, input logic [7:0] e_addr, input logic [7:0] e_instr,
                      input logic [7:0] e_pc, input logic e_v, input logic ck_pc);
    exp_t e;
    stall = st; redirect = rd; jmp_abs = ab; jmp_offset = off;
    e.name = name; e.addr = e_addr; e.instr = e_instr; e.pc = e_pc; e.valid = e_v; e.ck_pc = ck_pc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".addr"}, imem_addr, e.addr);
      chk({e.name, ".instr"}, if_instr, e.instr);
      chk({e.name, ".valid"}, {7'd0, if_valid}, {7'd0, e.valid});
      if (e.ck_pc) chk({e.name, ".pc"}, if_pc, e.pc);
    end
  end

  initial begin
    #2;
    chk("rst.addr", imem_addr, 8'h00);
    chk("rst.instr", if_instr, 8'h00);
    chk("rst.pc", if_pc, 8'h00);
    chk("rst.valid", {7'd0, if_valid}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Free run from reset
    step("run1", 0, 0, 0, 8'h00, 8'h01, 8'h10, 8'h00, 1, 1);
    step("run2", 0, 0, 0, 8'h00, 8'h02, 8'h11, 8'h01, 1, 1);
    step("run3", 0, 0, 0, 8'h00, 8'h03, 8'h12, 8'h02, 1, 1);
    step("run4", 0, 0, 0, 8'h00, 8'h04, 8'h13, 8'h03, 1, 1);
    step("run5", 0, 0, 0, 8'h00, 8'h05, 8'h14, 8'h04, 1, 1);
    // Stall at PC=5
    for (int i = 0; i < 3; i++)
      step("stall", 1, 0, 0, 8'h00, 8'h05, 8'h14, 8'h04, 1, 1);
    step("resume", 0, 0, 0, 8'h00, 8'h06, 8'h15, 8'h05, 1, 1);
    // if_pc=5, offset -1 -> 4, then if_pc=4, offset -2 -> 2
    step("rd_m1", 0, 1, 0, 8'hFF, 8'h04, 8'h00, 8'h00, 0, 0);
    step("rd_m1_f", 0, 0, 0, 8'h00, 8'h05, 8'h14, 8'h04, 1, 1);
    step("rd_m2", 0, 1, 0, 8'hFE, 8'h02, 8'h00, 8'h00, 0, 0);
    step("rd_m2_f", 0, 0, 0, 8'h00, 8'h03, 8'h12, 8'h02, 1, 1);
    // Wrap: if_pc=2 + FD -> FF, then FF -> 00
    step("rd_ff", 0, 1, 0, 8'hFD, 8'hFF, 8'h00, 8'h00, 0, 0);
    step("wrap1", 0, 0, 0, 8'h00, 8'h00, 8'h0F, 8'hFF, 1, 1);
    step("wrap2", 0, 0, 0, 8'h00, 8'h01, 8'h10, 8'h00, 1, 1);
    // if_pc=0 + F0 -> F0; if_pc=F0 + 20 -> 10
    step("rd_f0", 0, 1, 0, 8'hF0, 8'hF0, 8'h00, 8'h00, 0, 0);
    step("at_f0", 0, 0, 0, 8'h00, 8'hF1, 8'h00, 8'hF0, 1, 1);
    step("rd_p20", 0, 1, 0, 8'h20, 8'h10, 8'h00, 8'h00, 0, 0);
    step("at_10", 0, 0, 0, 8'h00, 8'h11, 8'h20, 8'h10, 1, 1);
    // Redirect wins over stall
    step("rd_stl", 1, 1, 0, 8'h05, 8'h15, 8'h00, 8'h00, 0, 0);
    step("stl_hold", 1, 0, 0, 8'h00, 8'h15, 8'h00, 8'h00, 0, 0);
    step("at_15", 0, 0, 0, 8'h00, 8'h16, 8'h25, 8'h15, 1, 1);

    // Asynchronous reset mid-cycle, overriding stall+redirect
    stall = 1'b1; redirect = 1'b1; jmp_offset = 8'h33;
    #2 reset = 1'b0;
    #1;
    chk("arst.addr", imem_addr, 8'h00);
    chk("arst.valid", {7'd0, if_valid}, 8'h00);
    chk("arst.instr", if_instr, 8'h00);
    chk("arst.pc", if_pc, 8'h00);
    @(posedge clk); #1;
    chk("arst_edge.addr", imem_addr, 8'h00);
    chk("arst_edge.valid", {7'd0, if_valid}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    step("rel1", 0, 0, 0, 8'h00, 8'h01, 8'h10, 8'h00, 1, 1);

`ifdef FETCH_ABS_JMP_EN
    step("to7", 0, 1, 0, 8'h07, 8'h07, 8'h00, 8'h00, 0, 0);
    step("at7", 0, 0, 0, 8'h00, 8'h08, 8'h17, 8'h07, 1, 1);
    step("abs40", 0, 1, 1, 8'h40, 8'h40, 8'h00, 8'h00, 0, 0);
    step("at40", 0, 0, 0, 8'h00, 8'h41, 8'h50, 8'h40, 1, 1);
    step("back7", 0, 1, 0, 8'hC7, 8'h07, 8'h00, 8'h00, 0, 0);
    step("at7b", 0, 0, 0, 8'h00, 8'h08, 8'h17, 8'h07, 1, 1);
    step("rel47", 0, 1, 0, 8'h40, 8'h47, 8'h00, 8'h00, 0, 0);
`endif

    stall = 1'b0; redirect = 1'b0; jmp_abs = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_W, default 8, meaning instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 The block SHALL have parameter NOP_INSTR, default 0, meaning the instruction value presented when if_valid is 0.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock, rising-edge active.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port stall, input, 1 bit, holding the PC and the IF/ID register.
REQ-008 The block SHALL have port redirect, input, 1 bit, signalling a taken branch or jump.
REQ-009 The block SHALL have port jmp_offset, input, PC_W bits, the two's-complement branch offset.
REQ-010 The block SHALL have port imem_addr, output, PC_W bits, the instruction-memory read address.
REQ-011 The block SHALL have port imem_data, input, INSTR_W bits, the instruction-memory read data, combinational from imem_addr.
REQ-012 The block SHALL have port if_instr, output, INSTR_W bits, the registered fetched instruction.
REQ-013 The block SHALL have port if_pc, output, PC_W bits, the registered PC of if_instr.
REQ-014 The block SHALL have port if_valid, output, 1 bit, set when if_instr is a valid instruction.

Function
REQ-015 imem_addr SHALL equal the internal PC register combinationally, with no added latency.
REQ-016 On a clock edge with redirect=0 and stall=0, the block SHALL load: PC<=PC+1, if_instr<=imem_data, if_pc<=PC, if_valid<=1.
REQ-017 On a clock edge with redirect=0 and stall=1, the block SHALL hold PC, if_instr, if_pc and if_valid unchanged.
REQ-018 On a clock edge with redirect=1, the block SHALL load PC<=if_pc+jmp_offset, so the target is relative to the PC of the instruction currently presented.
REQ-019 On that same redirect edge, the block SHALL load if_valid<=0 and if_instr<=NOP_INSTR, flushing the wrong-path fetch; if_pc is don't-care.
REQ-020 redirect SHALL take priority over stall; a redirect during a stall SHALL still update the PC and flush.
REQ-021 All PC arithmetic SHALL be modulo 2^PC_W: PC=2^PC_W-1 SHALL increment to 0, and a negative offset below 0 SHALL wrap.
REQ-022 Fetch latency SHALL be one cycle: an instruction at address A appears on if_instr on the edge after imem_addr=A.
REQ-023 The first valid instruction after a redirect SHALL appear on the second edge after the redirect edge (one bubble).
REQ-024 The block SHALL contain no other state; stall and redirect SHALL be sampled only at the rising clk edge.

Reset
REQ-025 On reset=0, the block SHALL asynchronously set PC=RESET_PC, if_valid=0, if_instr=NOP_INSTR and if_pc=RESET_PC, independent of clk.
REQ-026 On reset deassertion, the first rising edge SHALL fetch from RESET_PC, presenting if_valid=1 and if_pc=RESET_PC after that edge, unless stall or redirect is asserted.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL override all other inputs.

Configuration
REQ-028 With macro FETCH_ABS_JMP_EN defined, the block SHALL add input jmp_abs (1 bit); redirect with jmp_abs=1 SHALL load PC<=jmp_offset, and jmp_abs=0 SHALL keep the relative behaviour.
REQ-029 With FETCH_ABS_JMP_EN undefined, port jmp_abs SHALL be absent and all redirects SHALL be relative.

Verification
REQ-030 Reset release with imem_data=mem[addr]=addr+8'h10 and no stall/redirect -> after edges 1, 2, 3: if_pc=0, 1, 2 and if_instr=8'h10, 8'h11, 8'h12, with if_valid=1.
REQ-031 stall=1 for 3 cycles at PC=5 -> imem_addr stays 5 and if_instr/if_pc/if_valid remain frozen; fetch resumes with if_pc=5 after release.
REQ-032 redirect=1 with if_pc=4 and jmp_offset=8'hFE -> the next edge gives imem_addr=2 and if_valid=0, and the following edge gives if_pc=2 and if_valid=1.
REQ-033 PC=8'hFF, free-running -> if_pc=8'hFF, then 8'h00; redirect with if_pc=8'hF0 and jmp_offset=8'h20 -> PC=8'h10.
REQ-034 redirect=1 and stall=1 on the same edge -> the redirect is taken and the flush occurs; reset pulsed low mid-cycle -> PC=RESET_PC and if_valid=0 immediately, without waiting for a clock edge.
REQ-035 With FETCH_ABS_JMP_EN defined, redirect with jmp_abs=1 and jmp_offset=8'h40 at if_pc=8'h07 -> PC=8'h40; with jmp_abs=0 -> PC=8'h47.
